// File: rtl/pw_lock_pkg.sv
// Shared types, key codes and helpers for the digit-lock controller.
package pw_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5,
    ST_NEWPW   = 3'd6
  } pw_state_t;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pw_timer.sv
// Loadable down-counter with terminal-count flag; shared by OPEN and LOCKOUT.
module pw_timer #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down to zero and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pw_lock_ctrl.sv
// Digit-lock sequencing controller: key handling, compare, open, lockout, password change.
module pw_lock_ctrl
  import pw_lock_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned OPEN_CYC = 1000,
  parameter int unsigned LOCK_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       chg_mode,
  input  logic       pw_match,
  output logic       digit_wr,
  output logic [2:0] digit_idx,
  output logic [3:0] digit_data,
  output logic       entry_clr,
  output logic       cmp_req,
  output logic       pw_load,
  output logic       door_open,
  output logic       alarm,
  output logic [2:0] fail_cnt,
  output logic [2:0] state
);

  localparam int unsigned    TW      = $clog2(max_u(OPEN_CYC, LOCK_CYC) + 1);
  localparam logic [TW-1:0]  OPEN_LD = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0]  LOCK_LD = TW'(LOCK_CYC - 1);
  localparam logic [3:0]     DIG_N   = 4'(DIGITS);
  localparam logic [2:0]     FAIL_N  = 3'(MAX_FAIL);

  pw_state_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  fail_q, fail_d, fail_inc;
  logic        wr_q, wr_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  data_q, data_d;
  logic        clr_q, clr_d;
  logic        cmp_q, cmp_d;
  logic        load_q, load_d;
  logic        door_q, door_d;
  logic        alarm_q, alarm_d;
  logic        pend_q, pend_d;
  logic        in_np;
  logic        tmr_load, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_val;

  pw_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  assign tmr_en = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    wr_d     = 1'b0;
    idx_d    = idx_q;
    data_d   = data_q;
    clr_d    = 1'b0;
    load_d   = 1'b0;
    pend_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    in_np    = (state_q == ST_NEWPW);
    fail_inc = (fail_q >= FAIL_N) ? FAIL_N : fail_q + 3'd1;
    case (state_q)
      ST_IDLE, ST_ENTRY, ST_NEWPW: begin
        // pend_q marks the cycle after pw_load, when the buffer is cleared and NEWPW exits
        if (in_np && pend_q) begin
          clr_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (in_np && !chg_mode) begin
          clr_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (key_valid) begin
          if (is_digit(key_code)) begin
            if (cnt_q < DIG_N) begin
              wr_d    = 1'b1;
              idx_d   = cnt_q[2:0];
              data_d  = key_code;
              cnt_d   = cnt_q + 4'd1;
              state_d = in_np ? ST_NEWPW : ST_ENTRY;
            end
          end else if (key_code == KEY_CLR) begin
            clr_d   = 1'b1;
            cnt_d   = '0;
            state_d = in_np ? ST_NEWPW : ST_IDLE;
          end else if (key_code == KEY_ENT) begin
            if (cnt_q == DIG_N) begin
              if (in_np) begin
                load_d = 1'b1;
                pend_d = 1'b1;
              end else begin
                state_d = ST_CHECK;
              end
            end else begin
              clr_d   = 1'b1;
              cnt_d   = '0;
              state_d = in_np ? ST_NEWPW : ST_FAIL;
            end
          end
        end
      end
      ST_CHECK: begin
        clr_d = 1'b1;
        cnt_d = '0;
        if (pw_match) begin
          fail_d   = '0;
          state_d  = ST_OPEN;
          tmr_load = 1'b1;
          tmr_val  = OPEN_LD;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        fail_d = fail_inc;
        if (fail_inc == FAIL_N) begin
          state_d  = ST_LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = LOCK_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (chg_mode) begin
          clr_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_NEWPW;
        end else if (tmr_tc) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_tc) begin
          fail_d  = '0;
          clr_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    cmp_d   = (state_d == ST_CHECK);
    door_d  = (state_d == ST_OPEN) || (state_d == ST_NEWPW);
    alarm_d = (state_d == ST_LOCKOUT);
  end

  // State and output registers; entry_clr resets high so the buffer starts clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fail_q  <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      clr_q   <= 1'b1;
      cmp_q   <= 1'b0;
      load_q  <= 1'b0;
      door_q  <= 1'b0;
      alarm_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      clr_q   <= clr_d;
      cmp_q   <= cmp_d;
      load_q  <= load_d;
      door_q  <= door_d;
      alarm_q <= alarm_d;
      pend_q  <= pend_d;
    end
  end

  assign digit_wr   = wr_q;
  assign digit_idx  = idx_q;
  assign digit_data = data_q;
  assign entry_clr  = clr_q;
  assign cmp_req    = cmp_q;
  assign pw_load    = load_q;
  assign door_open  = door_q;
  assign alarm      = alarm_q;
  assign fail_cnt   = fail_q;
  assign state      = state_q;

endmodule
